// File: rtl/sys_bridge.sv
// sys_bridge: CPU data-bus responder; decodes loads/stores to DMEM, the timer block, or an unmapped-address error.
// Latency: DMEM req->cpu_ready = MEM_WAIT+2 cycles; timer/error = 1 cycle; next request sampled the cycle after ready.
// Backpressure: the CPU holds its request until the one-cycle cpu_ready pulse; requests seen during RESP are ignored.
//
// Ports: clk/rst (async active-high); cpu_* request/response channel; mem_* DMEM strobe/address/data
// (mem_rdata is sampled once the wait counter expires); irq = CTRL.IM & timer status.
module sys_bridge #(
    parameter int          DMEM_AW    = 12,
    parameter int          MEM_WAIT   = 1,
    parameter logic [31:0] TIMER_BASE = 32'h0000_7F00
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cpu_req,
    input  logic               cpu_we,
    input  logic [31:0]        cpu_addr,
    input  logic [3:0]         cpu_be,
    input  logic [31:0]        cpu_wdata,
    output logic [31:0]        cpu_rdata,
    output logic               cpu_ready,
    output logic               cpu_err,
    output logic               mem_en,
    output logic [3:0]         mem_we,
    output logic [DMEM_AW-1:0] mem_addr,
    output logic [31:0]        mem_wdata,
    input  logic [31:0]        mem_rdata,
    output logic               irq
);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} bus_state_t;
    typedef enum logic [1:0] {T_IDLE, T_LOAD, T_CNT, T_INT} tmr_state_t;

    bus_state_t         state, state_nxt;
    tmr_state_t         t_state, t_nxt;

    logic               req_we;
    logic [3:0]         req_be;
    logic [DMEM_AW-1:0] req_addr;
    logic [31:0]        req_wdata;
    logic [3:0]         wcnt;
    logic [31:0]        rdata_q;
    logic               err_q;

    logic [3:0]         ctrl;      // [0] EN, [2:1] MODE, [3] IM
    logic [31:0]        preset;
    logic [31:0]        count;
    logic               status;

    logic               take;
    logic [31:0]        toff;
    logic               dmem_hit;
    logic               tmr_hit;
    logic               tmr_ok;
    logic [1:0]         tmr_idx;
    logic               ctrl_wr;
    logic               preset_wr;
    logic [31:0]        tmr_rdata;
    logic               cnt_load;
    logic               cnt_dec;
    logic               expire;
    logic               en_clr;

    // Address decode, evaluated only while IDLE (take). DMEM has priority.
    assign take      = (state == IDLE) && cpu_req;
    assign toff      = cpu_addr - TIMER_BASE;
    assign dmem_hit  = (cpu_addr[31:DMEM_AW+2] == '0);
    assign tmr_hit   = !dmem_hit && (toff < 32'd12);
    assign tmr_idx   = toff[3:2];
    // Timer stores must be full-word and COUNT is read-only.
    assign tmr_ok    = tmr_hit && !(cpu_we && ((cpu_be != 4'hF) || (tmr_idx == 2'd2)));
    assign ctrl_wr   = take && tmr_ok && cpu_we && (tmr_idx == 2'd0);
    assign preset_wr = take && tmr_ok && cpu_we && (tmr_idx == 2'd1);

    always_comb begin
        tmr_rdata = count;
        case (tmr_idx)
            2'd0:    tmr_rdata = {28'd0, ctrl};
            2'd1:    tmr_rdata = preset;
            default: tmr_rdata = count;
        endcase
    end

    // Bus FSM
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        cpu_ready = 1'b0;
        mem_en    = 1'b0;
        case (state)
            IDLE:    if (cpu_req) state_nxt = dmem_hit ? ACCESS : RESP;
            ACCESS: begin
                mem_en = 1'b1;
                if (wcnt == 4'd0) state_nxt = RESP;
            end
            RESP: begin
                cpu_ready = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign cpu_rdata = cpu_ready ? rdata_q : 32'd0;
    assign cpu_err   = cpu_ready & err_q;
    assign mem_we    = (mem_en && req_we) ? req_be : 4'h0;
    assign mem_addr  = req_addr;
    assign mem_wdata = req_wdata;

    // Request latch and response data. Timer/error responses are resolved at
    // decode so RESP only has to present them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_we    <= 1'b0;
            req_be    <= 4'h0;
            req_addr  <= '0;
            req_wdata <= 32'd0;
            wcnt      <= 4'd0;
            rdata_q   <= 32'd0;
            err_q     <= 1'b0;
        end else if (take) begin
            req_we    <= cpu_we;
            req_be    <= cpu_be;
            req_addr  <= cpu_addr[DMEM_AW+1:2];
            req_wdata <= cpu_wdata;
            wcnt      <= 4'(MEM_WAIT);
            rdata_q   <= (tmr_ok && !cpu_we) ? tmr_rdata : 32'd0;
            err_q     <= !dmem_hit && !tmr_ok;
        end else if (state == ACCESS) begin
            if (wcnt == 4'd0) begin
                rdata_q <= mem_rdata;
                err_q   <= 1'b0;
            end else begin
                wcnt <= wcnt - 4'd1;
            end
        end
    end

    // Timer FSM
    always_ff @(posedge clk or posedge rst) begin
        if (rst) t_state <= T_IDLE;
        else     t_state <= t_nxt;
    end

    always_comb begin
        t_nxt    = t_state;
        cnt_load = 1'b0;
        cnt_dec  = 1'b0;
        expire   = 1'b0;
        en_clr   = 1'b0;
        case (t_state)
            T_IDLE: if (ctrl[0]) t_nxt = T_LOAD;
            T_LOAD: begin
                cnt_load = 1'b1;
                t_nxt    = T_CNT;
            end
            T_CNT: begin
                if (!ctrl[0])          t_nxt = T_IDLE;
                else if (count > 32'd1) cnt_dec = 1'b1;
                else begin
                    expire = 1'b1;
                    t_nxt  = T_INT;
                end
            end
            T_INT: begin
                if (ctrl[2:1] == 2'b01) t_nxt = T_LOAD;
                else begin
                    en_clr = 1'b1;
                    t_nxt  = T_IDLE;
                end
            end
            default: t_nxt = T_IDLE;
        endcase
        // Writing EN=0 parks the timer immediately, whatever it was doing.
        if (ctrl_wr && !cpu_wdata[0]) t_nxt = T_IDLE;
    end

    // CPU writes are applied last so they win over same-cycle timer updates.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ctrl   <= 4'h0;
            preset <= 32'd0;
            count  <= 32'd0;
            status <= 1'b0;
        end else begin
            if (cnt_load)     count <= preset;
            else if (cnt_dec) count <= count - 32'd1;
            else if (expire)  count <= 32'd0;
            if (expire) status  <= 1'b1;
            if (en_clr) ctrl[0] <= 1'b0;
            if (ctrl_wr) begin
                ctrl   <= cpu_wdata[3:0];
                status <= 1'b0;
            end
            if (preset_wr) preset <= cpu_wdata;
        end
    end

    assign irq = ctrl[3] & status;

endmodule

// File: tb/tb_sys_bridge.sv
// tb_sys_bridge: scoreboard bench for sys_bridge with a DMEM device model and reference models.
// Latency: n/a (testbench).
// Backpressure: driver holds each request until cpu_ready, bounded by a cycle budget.
module tb_sys_bridge;

    localparam int DMEM_AW  = 12;
    localparam int MEM_WAIT = 1;
    localparam int LAT_MEM  = MEM_WAIT + 2;

    logic               clk;
    logic               rst;
    logic               cpu_req;
    logic               cpu_we;
    logic [31:0]        cpu_addr;
    logic [3:0]         cpu_be;
    logic [31:0]        cpu_wdata;
    logic [31:0]        cpu_rdata;
    logic               cpu_ready;
    logic               cpu_err;
    logic               mem_en;
    logic [3:0]         mem_we;
    logic [DMEM_AW-1:0] mem_addr;
    logic [31:0]        mem_wdata;
    logic [31:0]        mem_rdata;
    logic               irq;

    sys_bridge #(.DMEM_AW(DMEM_AW), .MEM_WAIT(MEM_WAIT), .TIMER_BASE(32'h0000_7F00)) dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_be(cpu_be),
        .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready), .cpu_err(cpu_err),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .irq(irq)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int chk  = 0;
    int errs = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        chk++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // DMEM device: read data is only valid once the strobe has been up long enough.
    logic [31:0] dmem [0:(1<<DMEM_AW)-1];
    int          en_cnt = 0;
    initial for (int i = 0; i < (1<<DMEM_AW); i++) dmem[i] = 32'd0;
    always @(posedge clk) begin
        if (mem_en) begin
            for (int b = 0; b < 4; b++)
                if (mem_we[b]) dmem[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
            en_cnt <= en_cnt + 1;
        end else begin
            en_cnt <= 0;
        end
    end
    assign mem_rdata = (mem_en && en_cnt >= MEM_WAIT) ? dmem[mem_addr] : 32'hA5A5_5A5A;

    // Reference state
    logic [31:0] ref_mem [int];
    logic [3:0]  m_ctrl;
    logic [31:0] m_preset;

    function automatic logic [31:0] ref_read(input logic [31:0] a);
        int w = int'(a >> 2);
        return ref_mem.exists(w) ? ref_mem[w] : 32'd0;
    endfunction

    task automatic ref_write(input logic [31:0] a, input logic [3:0] be, input logic [31:0] d);
        int w = int'(a >> 2);
        logic [31:0] v = ref_read(a);
        for (int b = 0; b < 4; b++)
            if (be[b]) v[8*b +: 8] = d[8*b +: 8];
        ref_mem[w] = v;
    endtask

    // Auto-reload COUNT as seen in cycle R+j after a CTRL write whose ready
    // pulse is at cycle R (period = load + p counting cycles + interrupt).
    function automatic logic [31:0] ar_count(input int j, input int p);
        int m;
        if (j <= 0) return 32'd0;
        m = (j - 1) % (p + 2);
        if (m == 0 || m == p + 1) return 32'd0;
        return 32'(p - m + 1);
    endfunction

    // Scoreboard
    typedef struct {
        logic        chk_rd;
        logic [31:0] rd;
        logic        err;
        int          lat;
        int          issue;
        int          id;
    } exp_t;

    exp_t sbq[$];
    exp_t mon_e;
    int   op_id = 0;

    logic        cur_we;
    logic [31:0] cur_addr;
    logic [3:0]  cur_be;
    logic [31:0] cur_wdata;
    int          last_ready = 0;

    always @(negedge clk) begin
        if (!rst && cpu_ready) begin
            if (sbq.size() == 0) begin
                chk++;
                errs++;
                $display("FAIL unexpected_ready: cpu_ready=1 with nothing outstanding (cycle %0d)", cyc);
            end else begin
                mon_e = sbq.pop_front();
                check($sformatf("latency#%0d", mon_e.id), 32'(cyc - mon_e.issue), 32'(mon_e.lat));
                check($sformatf("err#%0d", mon_e.id), {31'd0, cpu_err}, {31'd0, mon_e.err});
                if (mon_e.chk_rd)
                    check($sformatf("rdata#%0d", mon_e.id), cpu_rdata, mon_e.rd);
            end
        end
    end

    // DMEM strobe monitor: address/enables/data must follow the request in flight.
    always @(negedge clk) begin
        if (!rst && mem_en) begin
            check("mem_addr", {20'd0, mem_addr}, {20'd0, cur_addr[DMEM_AW+1:2]});
            check("mem_we", {28'd0, mem_we}, {28'd0, (cur_we ? cur_be : 4'h0)});
            if (cur_we) check("mem_wdata", mem_wdata, cur_wdata);
        end
    end

    task automatic access(input logic we, input logic [31:0] addr, input logic [3:0] be,
                          input logic [31:0] wd, input logic chk_rd, input logic [31:0] exp_rd,
                          input logic exp_err, input int lat);
        exp_t e;
        int   n;
        op_id++;
        e.chk_rd = chk_rd; e.rd = exp_rd; e.err = exp_err;
        e.lat = lat; e.issue = cyc; e.id = op_id;
        sbq.push_back(e);
        cur_we = we; cur_addr = addr; cur_be = be; cur_wdata = wd;
        cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_be = be; cpu_wdata = wd;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!cpu_ready && n < 20);
        if (!cpu_ready) begin
            chk++;
            errs++;
            $display("FAIL ready_timeout#%0d: no cpu_ready within 20 cycles, required one", op_id);
        end
        last_ready = cyc;
        cpu_req = 1'b0;
        @(negedge clk);
    endtask

    task automatic tload(input logic [31:0] a, input logic [31:0] exp);
        access(1'b0, a, 4'hF, $urandom, 1'b1, exp, 1'b0, 1);
    endtask

    task automatic tstore(input logic [31:0] a, input logic [31:0] d);
        access(1'b1, a, 4'hF, d, 1'b0, 32'd0, 1'b0, 1);
    endtask

    task automatic wait_cyc(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    localparam logic [31:0] A_CTRL   = 32'h0000_7F00;
    localparam logic [31:0] A_PRESET = 32'h0000_7F04;
    localparam logic [31:0] A_COUNT  = 32'h0000_7F08;

    initial begin
        int          r;
        int          c;
        int          k;
        logic [31:0] a;
        logic [31:0] d;
        logic [3:0]  be;
        logic        we;

        rst = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 32'd0; cpu_be = 4'h0; cpu_wdata = 32'd0;
        cur_we = 1'b0; cur_addr = 32'd0; cur_be = 4'h0; cur_wdata = 32'd0;
        m_ctrl = 4'h0; m_preset = 32'd0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_ready", {31'd0, cpu_ready}, 32'd0);
        check("rst_err", {31'd0, cpu_err}, 32'd0);
        check("rst_rdata", cpu_rdata, 32'd0);
        check("rst_mem_en", {31'd0, mem_en}, 32'd0);
        check("rst_mem_we", {28'd0, mem_we}, 32'd0);
        check("rst_mem_addr", {20'd0, mem_addr}, 32'd0);
        check("rst_mem_wdata", mem_wdata, 32'd0);
        check("rst_irq", {31'd0, irq}, 32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check("idle_irq", {31'd0, irq}, 32'd0);
        tload(A_COUNT, 32'd0);

        // DMEM directed: full and partial stores, loads back
        access(1'b1, 32'h10, 4'hF, 32'hDEAD_BEEF, 1'b0, 32'd0, 1'b0, LAT_MEM);
        ref_write(32'h10, 4'hF, 32'hDEAD_BEEF);
        access(1'b0, 32'h10, 4'hF, 32'd0, 1'b1, ref_read(32'h10), 1'b0, LAT_MEM);
        access(1'b1, 32'h10, 4'b0011, 32'h1122_3344, 1'b0, 32'd0, 1'b0, LAT_MEM);
        ref_write(32'h10, 4'b0011, 32'h1122_3344);
        access(1'b0, 32'h13, 4'hF, 32'd0, 1'b1, 32'hDEAD_3344, 1'b0, LAT_MEM);

        // One-shot timer: PRESET=5, CTRL=EN|IM
        tstore(A_PRESET, 32'd5);
        tstore(A_CTRL, 32'h9);
        r = last_ready;
        wait_cyc(r + 6);
        check("oneshot_irq_early", {31'd0, irq}, 32'd0);
        wait_cyc(r + 7);
        check("oneshot_irq_set", {31'd0, irq}, 32'd1);
        wait_cyc(r + 8);
        tload(A_CTRL, 32'h8);
        tload(A_COUNT, 32'd0);
        check("oneshot_irq_held", {31'd0, irq}, 32'd1);
        tstore(A_CTRL, 32'h8);
        check("ctrl_wr_clears_irq", {31'd0, irq}, 32'd0);
        m_ctrl = 4'h8; m_preset = 32'd5;

        // Error responses, no state change
        access(1'b0, 32'h4000_0000, 4'hF, 32'd0, 1'b1, 32'd0, 1'b1, 1);
        access(1'b1, A_COUNT, 4'hF, 32'h55, 1'b1, 32'd0, 1'b1, 1);
        tload(A_COUNT, 32'd0);
        access(1'b1, A_CTRL, 4'h1, 32'hF, 1'b1, 32'd0, 1'b1, 1);
        tload(A_CTRL, 32'h8);
        access(1'b0, 32'h0000_7F0C, 4'hF, 32'd0, 1'b1, 32'd0, 1'b1, 1);
        access(1'b1, A_PRESET, 4'h7, 32'h77, 1'b1, 32'd0, 1'b1, 1);
        tload(A_PRESET, 32'd5);

        // Auto-reload: PRESET=3, CTRL=EN|MODE01|IM
        tstore(A_PRESET, 32'd3);
        tstore(A_CTRL, 32'hB);
        r = last_ready;
        for (int i = 0; i < 10; i++) begin
            if ($urandom_range(0, 1) == 1) @(negedge clk);
            c = cyc;
            check("ar_irq", {31'd0, irq}, {31'd0, (c - r >= 5)});
            tload(A_COUNT, ar_count(c - r, 3));
        end
        tstore(A_CTRL, 32'h8);
        check("ar_stop_irq", {31'd0, irq}, 32'd0);
        m_ctrl = 4'h8; m_preset = 32'd3;

        // Randomized traffic against the reference models (timer stopped)
        for (int i = 0; i < 60; i++) begin
            k  = $urandom_range(0, 9);
            we = 1'($urandom_range(0, 1));
            be = 4'($urandom_range(0, 15));
            d  = $urandom;
            if (k <= 5) begin
                a = (k == 5) ? 32'($urandom_range(0, (1<<DMEM_AW) - 1)) << 2
                             : 32'($urandom_range(0, 15)) << 2;
                a = a | 32'($urandom_range(0, 3));
                if (we) begin
                    access(1'b1, a, be, d, 1'b0, 32'd0, 1'b0, LAT_MEM);
                    ref_write(a, be, d);
                end else begin
                    access(1'b0, a, be, d, 1'b1, ref_read(a), 1'b0, LAT_MEM);
                end
            end else if (k == 6) begin
                case ($urandom_range(0, 2))
                    0:       a = 32'($urandom_range(32'h4000, 32'h7EFF));
                    1:       a = 32'h7F0C + 32'($urandom_range(0, 243));
                    default: a = 32'h8000 + 32'($urandom_range(0, 32'h7FFF_0000));
                endcase
                access(we, a, be, d, 1'b1, 32'd0, 1'b1, 1);
            end else if (k == 7) begin
                tstore(A_PRESET, d);
                m_preset = d;
            end else if (k == 8) begin
                tload(A_PRESET, m_preset);
            end else begin
                tload(A_CTRL, {28'd0, m_ctrl});
            end
        end

        // Reset pulsed while a DMEM access is in flight
        op_id++;
        cur_we = 1'b0; cur_addr = 32'h20; cur_be = 4'hF; cur_wdata = 32'd0;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h20; cpu_be = 4'hF; cpu_wdata = 32'd0;
        @(negedge clk);
        check("abort_in_access", {31'd0, mem_en}, 32'd1);
        rst = 1'b1;
        cpu_req = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("abort_no_ready", {31'd0, cpu_ready}, 32'd0);
        end
        m_ctrl = 4'h0; m_preset = 32'd0;
        access(1'b0, 32'h10, 4'hF, 32'd0, 1'b1, ref_read(32'h10), 1'b0, LAT_MEM);
        tload(A_CTRL, 32'd0);
        tload(A_PRESET, 32'd0);

        // CTRL write landing on the same edge the count expires
        tstore(A_PRESET, 32'd2);
        tstore(A_CTRL, 32'h9);
        r = last_ready;
        wait_cyc(r + 3);
        tstore(A_CTRL, 32'h8);
        check("coincide_irq", {31'd0, irq}, 32'd0);
        repeat (3) @(negedge clk);
        check("coincide_irq_later", {31'd0, irq}, 32'd0);
        tload(A_CTRL, 32'h8);

        repeat (4) @(negedge clk);
        check("sb_drained", 32'(sbq.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", chk, errs);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1);
    end

endmodule
